// File: rtl/edge_detect_array.sv
// -----------------------------------------------------------------------------
// edge_detect_array
//
// Multi-channel edge detector for asynchronous inputs. Each channel is
// synchronised, optionally debounced, and turned into a filtered level, a
// single-cycle edge pulse (direction chosen by mode) and a sticky event flag.
//
// Configuration macro:
//   EDGE_DETECT_DEBOUNCE_EN  defined   -> per-channel debounce counters; a level
//                                         change is accepted after DEB_CYCLES
//                                         consecutive differing samples.
//                            undefined -> no counters; level_out follows the
//                                         synchroniser output one clock later.
//
// Parameters:
//   NCH          number of independent channels (1..32)
//   SYNC_STAGES  synchroniser depth per channel (2..4)
//   DEB_CYCLES   stable samples needed to accept a change (1..255)
//
// Ports:
//   clk          single clock
//   rst          synchronous, active-high reset
//   signal_in    [NCH] asynchronous channel inputs
//   mode         [2]   edge select for all channels: 00 none, 01 rising,
//                      10 falling, 11 both
//   event_clr    [NCH] per-channel clear of the sticky flag
//   level_out    [NCH] accepted (filtered) level
//   edge_pulse   [NCH] one-clock pulse per accepted edge enabled by mode
//   event_flag   [NCH] sticky record of any edge_pulse since the last clear
// -----------------------------------------------------------------------------
module edge_detect_array #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] signal_in,
    input  logic [1:0]     mode,
    input  logic [NCH-1:0] event_clr,
    output logic [NCH-1:0] level_out,
    output logic [NCH-1:0] edge_pulse,
    output logic [NCH-1:0] event_flag
);

    // -------------------------------------------------------------------------
    // Synchroniser: stage 0 captures the raw input, the last stage is sync_q.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NCH-1:0] sync_ff;
    logic [NCH-1:0]                  sync_q;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // NOTE: every register below uses non-blocking assignment so all flops
    // sample the pre-edge values of their neighbours, which is what makes the
    // chain shift by exactly one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff[0] <= signal_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= sync_ff[s-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Level acceptance
    // -------------------------------------------------------------------------
    logic [NCH-1:0] level_next;

`ifdef EDGE_DETECT_DEBOUNCE_EN
    localparam int                CNT_W    = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Counts consecutive clocks in which sync_q disagrees with level_out.
    logic [NCH-1:0][CNT_W-1:0] match_cnt;
    logic [NCH-1:0][CNT_W-1:0] cnt_next;

    // NOTE: each signal is given a default before any conditional logic so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        level_next = level_out;
        cnt_next   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync_q[i] != level_out[i]) begin
                if (match_cnt[i] == CNT_LAST) begin
                    // The mismatch survived DEB_CYCLES samples: accept it.
                    level_next[i] = sync_q[i];
                    cnt_next[i]   = '0;
                end else begin
                    cnt_next[i] = match_cnt[i] + CNT_W'(1);
                end
            end
            // Agreement leaves cnt_next at 0, discarding any partial count.
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else begin
            match_cnt <= cnt_next;
        end
    end
`else
    // Without debounce the accepted level is simply the synchroniser output.
    assign level_next = sync_q;
`endif

    // -------------------------------------------------------------------------
    // Edge classification and sticky flags. mode is applied to the transition
    // happening in this clock only, so changing it never affects past edges.
    // -------------------------------------------------------------------------
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] pulse_next;
    logic [NCH-1:0] flag_next;

    always_comb begin
        rise       = level_next & ~level_out & {NCH{mode[0]}};
        fall       = ~level_next & level_out & {NCH{mode[1]}};
        pulse_next = rise | fall;
        // A pulse in the same clock as a clear wins, so no event is lost.
        flag_next  = edge_pulse | (event_flag & ~event_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_out  <= '0;
            edge_pulse <= '0;
            event_flag <= '0;
        end else begin
            level_out  <= level_next;
            edge_pulse <= pulse_next;
            event_flag <= flag_next;
        end
    end

endmodule

// File: tb/tb_edge_detect_array.sv
// -----------------------------------------------------------------------------
// tb_edge_detect_array
//
// Directed bench for edge_detect_array (NCH=4, SYNC_STAGES=2, DEB_CYCLES=4).
// Stimulus is one linear sequence; each step pushes the outputs expected at a
// given clock edge into a scoreboard, and a checker on the falling clock edge
// pops and compares the entries due at the most recent rising edge.
// Rising edges are numbered from 1; a value captured by the first
// synchroniser stage at edge k reaches level_out at edge k+LAT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_edge_detect_array;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int DEB = 4;
`ifdef EDGE_DETECT_DEBOUNCE_EN
    localparam int LAT = SS - 1 + DEB;
`else
    localparam int LAT = SS;
`endif

    logic           clk;
    logic           rst;
    logic [NCH-1:0] signal_in;
    logic [1:0]     mode;
    logic [NCH-1:0] event_clr;
    logic [NCH-1:0] level_out;
    logic [NCH-1:0] edge_pulse;
    logic [NCH-1:0] event_flag;

    edge_detect_array #(
        .NCH         (NCH),
        .SYNC_STAGES (SS),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .mode       (mode),
        .event_clr  (event_clr),
        .level_out  (level_out),
        .edge_pulse (edge_pulse),
        .event_flag (event_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int             edge_no;
        int             ph;
        logic [NCH-1:0] lvl;
        logic [NCH-1:0] pls;
        logic [NCH-1:0] flg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   sb_idx;

    task automatic push(input int e, input int ph, input logic [NCH-1:0] lvl,
                        input logic [NCH-1:0] pls, input logic [NCH-1:0] flg);
        exp_t x;
        x.edge_no = e;
        x.ph      = ph;
        x.lvl     = lvl;
        x.pls     = pls;
        x.flg     = flg;
        sb.push_back(x);
    endtask

    // Return 2 time units after rising edge n.
    task automatic wait_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    // Scoreboard checker, sampling away from the active edge.
    always @(negedge clk) begin
        sb_idx = 0;
        while (sb_idx < sb.size()) begin
            if (sb[sb_idx].edge_no == edge_n) begin
                checks++;
                assert (level_out === sb[sb_idx].lvl) else begin
                    errors++;
                    $error("FAIL ph%0d level_out edge %0d got %b exp %b",
                           sb[sb_idx].ph, edge_n, level_out, sb[sb_idx].lvl);
                end
                checks++;
                assert (edge_pulse === sb[sb_idx].pls) else begin
                    errors++;
                    $error("FAIL ph%0d edge_pulse edge %0d got %b exp %b",
                           sb[sb_idx].ph, edge_n, edge_pulse, sb[sb_idx].pls);
                end
                checks++;
                assert (event_flag === sb[sb_idx].flg) else begin
                    errors++;
                    $error("FAIL ph%0d event_flag edge %0d got %b exp %b",
                           sb[sb_idx].ph, edge_n, event_flag, sb[sb_idx].flg);
                end
                sb.delete(sb_idx);
            end else begin
                sb_idx++;
            end
        end
    end

    initial begin
        int g;
        rst       = 1'b1;
        signal_in = '0;
        mode      = 2'b00;
        event_clr = '0;

        // Phase 1: reset, all outputs zero from the first edge on.
        for (int e = 1; e <= 9; e++) push(e, 1, 4'b0000, 4'b0000, 4'b0000);
        wait_edge(2);
        rst  = 1'b0;
        mode = 2'b01;

        // Phase 2: ch0 rises (captured at edge 10), rising edges enabled.
        wait_edge(9);
        signal_in[0] = 1'b1;
        push(10 + LAT - 1, 2, 4'b0000, 4'b0000, 4'b0000);
        push(10 + LAT,     2, 4'b0001, 4'b0001, 4'b0000);
        push(10 + LAT + 1, 2, 4'b0001, 4'b0000, 4'b0001);

        // Phase 3: 3-clock pulse on ch1 with both edges enabled.
        wait_edge(19);
        mode = 2'b11;
        wait_edge(20);
        signal_in[1] = 1'b1;
`ifdef EDGE_DETECT_DEBOUNCE_EN
        // Too short to be accepted: nothing changes.
        for (int e = 21; e <= 30; e++) push(e, 3, 4'b0001, 4'b0000, 4'b0001);
`else
        // Passed straight through: rise at 23, fall at 26.
        push(22, 3, 4'b0001, 4'b0000, 4'b0001);
        push(23, 3, 4'b0011, 4'b0010, 4'b0001);
        push(24, 3, 4'b0011, 4'b0000, 4'b0011);
        push(25, 3, 4'b0011, 4'b0000, 4'b0011);
        push(26, 3, 4'b0001, 4'b0010, 4'b0011);
        push(27, 3, 4'b0001, 4'b0000, 4'b0011);
        push(28, 3, 4'b0001, 4'b0000, 4'b0011);
        push(29, 3, 4'b0001, 4'b0000, 4'b0001);
        push(30, 3, 4'b0001, 4'b0000, 4'b0001);
`endif
        wait_edge(23);
        signal_in[1] = 1'b0;
        wait_edge(28);
        event_clr = 4'b0010;
        wait_edge(29);
        event_clr = 4'b0000;

        // Phase 4: falling-only mode; ch2/ch3 rise silently, then fall together.
        wait_edge(30);
        mode = 2'b10;
        wait_edge(31);
        signal_in[3:2] = 2'b11;
        push(32 + LAT - 1, 4, 4'b0001, 4'b0000, 4'b0001);
        push(32 + LAT,     4, 4'b1101, 4'b0000, 4'b0001);
        wait_edge(40);
        signal_in[3:2] = 2'b00;
        push(41 + LAT - 1, 4, 4'b1101, 4'b0000, 4'b0001);
        push(41 + LAT,     4, 4'b0001, 4'b1100, 4'b0001);
        push(41 + LAT + 1, 4, 4'b0001, 4'b0000, 4'b1101);

        // Phase 5: ch0 falls; clear coincides with its pulse, then plain clears.
        wait_edge(50);
        signal_in[0] = 1'b0;
        g = 51 + LAT;
        push(g,     5, 4'b0000, 4'b0001, 4'b1101);
        push(g + 1, 5, 4'b0000, 4'b0000, 4'b1101);
        push(g + 3, 5, 4'b0000, 4'b0000, 4'b1100);
        push(g + 5, 5, 4'b0000, 4'b0000, 4'b0000);
        wait_edge(g);
        event_clr = 4'b0001;
        wait_edge(g + 1);
        event_clr = 4'b0000;
        wait_edge(g + 2);
        event_clr = 4'b0001;
        wait_edge(g + 3);
        event_clr = 4'b1100;
        wait_edge(g + 4);
        event_clr = 4'b1100;
        wait_edge(g + 5);
        event_clr = 4'b0000;

        // Phase 6: reset lands while ch0 is two counts into debouncing a rise.
        wait_edge(64);
        mode = 2'b11;
        wait_edge(65);
        signal_in[0] = 1'b1;
`ifdef EDGE_DETECT_DEBOUNCE_EN
        push(69, 6, 4'b0000, 4'b0000, 4'b0000);
`else
        push(68, 6, 4'b0001, 4'b0001, 4'b0000);
        push(69, 6, 4'b0001, 4'b0000, 4'b0001);
`endif
        wait_edge(69);
        rst       = 1'b1;
        signal_in = '0;
        for (int e = 70; e <= 79; e++) push(e, 6, 4'b0000, 4'b0000, 4'b0000);
        wait_edge(70);
        rst = 1'b0;

        // Phase 7: ch0 already high through reset is reported as a rise.
        wait_edge(80);
        rst          = 1'b1;
        signal_in[0] = 1'b1;
        push(81,           7, 4'b0000, 4'b0000, 4'b0000);
        push(82 + LAT - 1, 7, 4'b0000, 4'b0000, 4'b0000);
        push(82 + LAT,     7, 4'b0001, 4'b0001, 4'b0000);
        push(82 + LAT + 1, 7, 4'b0001, 4'b0000, 4'b0001);
        wait_edge(81);
        rst = 1'b0;

        wait_edge(95);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain left %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
